// File: rtl/day_trading_pkg.sv
// Shared definitions for the day_trading feeder and decision stages:
// action codes, packed word layout and the price window fill states.
package day_trading_pkg;

  localparam int unsigned PRICE_W = 5;
  localparam int unsigned ACT_W   = 16;
  localparam int unsigned WORD_W  = 16;

  localparam logic [ACT_W-1:0] ACT_SELL_ALL   = 16'd1;
  localparam logic [ACT_W-1:0] ACT_STAY_OUT   = 16'd2;
  localparam logic [ACT_W-1:0] ACT_BUY_MORE   = 16'd3;
  localparam logic [ACT_W-1:0] ACT_BUY_LOT    = 16'd4;
  localparam logic [ACT_W-1:0] ACT_BUY_LITTLE = 16'd7;
  localparam logic [ACT_W-1:0] ACT_HOLD       = 16'd8;

  localparam int unsigned OWN_BIT  = 15;
  localparam int unsigned DAY1_LSB = 10;
  localparam int unsigned DAY2_LSB = 5;
  localparam int unsigned DAY3_LSB = 0;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FILL1  = 2'd1,
    FILL2  = 2'd2,
    STREAM = 2'd3
  } fill_state_e;

endpackage

// File: rtl/own_tracker.sv
// Ownership tracker: decodes decision-stage action codes into the own flag
// and flags unrecognised codes with a one-cycle bad_action pulse.
module own_tracker
  import day_trading_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             action_valid,
  input  logic [ACT_W-1:0] action_in,
  output logic             own_next_c,
  output logic             own_out,
  output logic             bad_action
);

  logic own_q, own_d;
  logic bad_q, bad_d;

  always_comb begin
    own_d = own_q;
    bad_d = 1'b0;
    if (action_valid) begin
      case (action_in)
        ACT_SELL_ALL:                            own_d = 1'b0;
        ACT_BUY_MORE, ACT_BUY_LOT, ACT_BUY_LITTLE: own_d = 1'b1;
        ACT_STAY_OUT, ACT_HOLD:                  own_d = own_q;
        default:                                 bad_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      own_q <= own_d;
      bad_q <= bad_d;
    end
  end

  // Same-cycle value so a price accepted alongside an action packs the new own.
  assign own_next_c = own_d;
  assign own_out    = own_q;
  assign bad_action = bad_q;

endmodule

// File: rtl/price_window_packer.sv
// Sliding 3-day price window feeding the day_trading decision stage.
// Optional build macro PRICE_SAT_EN: saturate over-range prices instead of truncating.
module price_window_packer
  import day_trading_pkg::*;
#(
  parameter int unsigned IN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              price_valid,
  input  logic [IN_W-1:0]   price_in,
  output logic              price_ready,
  input  logic              action_valid,
  input  logic [ACT_W-1:0]  action_in,
  output logic [WORD_W-1:0] stock_out,
  output logic              stock_valid,
  input  logic              stock_ready,
  output logic              own_out,
  output logic              bad_action
);

  fill_state_e        state_q, state_d;
  logic [PRICE_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [WORD_W-1:0]  stock_q, stock_d;
  logic               valid_q, valid_d;
  logic               accept_c, emit_c, own_next_c;
  logic [PRICE_W-1:0] price_nar_c;

  own_tracker u_own_tracker (
    .clk          (clk),
    .rst          (rst),
    .action_valid (action_valid),
    .action_in    (action_in),
    .own_next_c   (own_next_c),
    .own_out      (own_out),
    .bad_action   (bad_action)
  );

  assign price_ready = !flush && (!valid_q || stock_ready);
  assign accept_c    = price_valid && price_ready;

`ifdef PRICE_SAT_EN
  localparam logic [IN_W-1:0] PRICE_MAX = IN_W'((1 << PRICE_W) - 1);
  assign price_nar_c = (price_in > PRICE_MAX) ? PRICE_W'((1 << PRICE_W) - 1)
                                              : price_in[PRICE_W-1:0];
`else
  logic unused_price_hi;
  assign unused_price_hi = |price_in[IN_W-1:PRICE_W];
  assign price_nar_c     = price_in[PRICE_W-1:0];
`endif

  // Fill state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Fill next-state: advance per accepted price, STREAM holds until flush.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept_c) begin
      case (state_q)
        EMPTY:   state_d = FILL1;
        FILL1:   state_d = FILL2;
        default: state_d = STREAM;
      endcase
    end
  end

  // Fill output decode: a full window after this accept produces a word.
  always_comb begin
    emit_c = 1'b0;
    if (accept_c && (state_q == FILL2 || state_q == STREAM)) emit_c = 1'b1;
  end

  // Window shift and one-entry output register.
  always_comb begin
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    stock_d = stock_q;
    valid_d = valid_q;
    if (flush) begin
      d1_d    = '0;
      d2_d    = '0;
      d3_d    = '0;
      valid_d = 1'b0;
    end else begin
      if (accept_c) begin
        d1_d = d2_q;
        d2_d = d3_q;
        d3_d = price_nar_c;
      end
      if (emit_c) begin
        stock_d                       = '0;
        stock_d[OWN_BIT]              = own_next_c;
        stock_d[DAY1_LSB +: PRICE_W]  = d2_q;
        stock_d[DAY2_LSB +: PRICE_W]  = d3_q;
        stock_d[DAY3_LSB +: PRICE_W]  = price_nar_c;
        valid_d                       = 1'b1;
      end else if (stock_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      stock_q <= '0;
      valid_q <= 1'b0;
    end else begin
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      stock_q <= stock_d;
      valid_q <= valid_d;
    end
  end

  assign stock_out   = stock_q;
  assign stock_valid = valid_q;

endmodule

// File: tb/tb_price_window_packer.sv
// Directed self-checking bench for price_window_packer (expected words hand-computed).
module tb_price_window_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        price_valid;
  logic [7:0]  price_in;
  logic        price_ready;
  logic        action_valid;
  logic [15:0] action_in;
  logic [15:0] stock_out;
  logic        stock_valid;
  logic        stock_ready;
  logic        own_out;
  logic        bad_action;

  int errors = 0;
  int checks = 0;

  price_window_packer #(.IN_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .price_valid  (price_valid),
    .price_in     (price_in),
    .price_ready  (price_ready),
    .action_valid (action_valid),
    .action_in    (action_in),
    .stock_out    (stock_out),
    .stock_valid  (stock_valid),
    .stock_ready  (stock_ready),
    .own_out      (own_out),
    .bad_action   (bad_action)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; price_valid = 1'b0; price_in = '0;
    action_valid = 1'b0; action_in = '0; stock_ready = 1'b1;
    #3;
    check("rst_valid", 16'(stock_valid), 16'd0);
    check("rst_out", stock_out, 16'h0000);
    check("rst_own", 16'(own_out), 16'd0);
    check("rst_bad", 16'(bad_action), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rdy_after_rst", 16'(price_ready), 16'd1);

    // Window fill with 10,10,10
    price_valid = 1'b1; price_in = 8'd10;
    cyc(); check("fill1_valid", 16'(stock_valid), 16'd0);
    cyc(); check("fill2_valid", 16'(stock_valid), 16'd0);
    cyc(); check("fill3_valid", 16'(stock_valid), 16'd1);
    check("fill3_out", stock_out, 16'h294A);

    price_in = 8'd13;
    cyc(); check("stream13_out", stock_out, 16'h294D);

    action_valid = 1'b1; action_in = 16'd7; price_in = 8'd12;
    cyc(); check("buy_own", 16'(own_out), 16'd1);
    check("buy_out", stock_out, 16'hA9AC);

    action_in = 16'd1; price_valid = 1'b0;
    cyc(); check("sell_own", 16'(own_out), 16'd0);
    check("drain_valid", 16'(stock_valid), 16'd0);
    action_valid = 1'b0;

    // Backpressure
    price_valid = 1'b1; price_in = 8'd5; stock_ready = 1'b0;
    cyc(); check("bp_emit", stock_out, 16'h3585);
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 16'(price_ready), 16'd0);
      check("bp_hold", stock_out, 16'h3585);
      check("bp_valid", 16'(stock_valid), 16'd1);
      cyc();
    end
    price_in = 8'd9; stock_ready = 1'b1;
    #1;
    check("bp_release_rdy", 16'(price_ready), 16'd1);
    cyc(); check("swap_out", stock_out, 16'h30A9);
    check("swap_valid", 16'(stock_valid), 16'd1);

    // Over-range price
    price_in = 8'd200;
    cyc();
`ifdef PRICE_SAT_EN
    check("ovr_out", stock_out, 16'h153F);
`else
    check("ovr_out", stock_out, 16'h1528);
`endif

    // Buy, then flush tests
    price_valid = 1'b0; action_valid = 1'b1; action_in = 16'd4;
    cyc(); check("buylot_own", 16'(own_out), 16'd1);
    action_valid = 1'b0;
    flush = 1'b1; price_valid = 1'b1; price_in = 8'd3;
    #1;
    check("flush_rdy", 16'(price_ready), 16'd0);
    cyc(); check("flush_valid", 16'(stock_valid), 16'd0);
    flush = 1'b0;
    cyc(); check("pf_a1", 16'(stock_valid), 16'd0);
    cyc(); check("pf_a2", 16'(stock_valid), 16'd0);
    flush = 1'b1;
    cyc(); check("flush2_valid", 16'(stock_valid), 16'd0);
    check("flush2_own", 16'(own_out), 16'd1);
    flush = 1'b0; price_in = 8'd1;
    cyc(); check("rf_a1", 16'(stock_valid), 16'd0);
    price_in = 8'd2;
    cyc(); check("rf_a2", 16'(stock_valid), 16'd0);
    price_in = 8'd3;
    cyc(); check("rf_a3_valid", 16'(stock_valid), 16'd1);
    check("rf_a3_out", stock_out, 16'h8443);

    // Unknown action code
    price_valid = 1'b0; action_valid = 1'b1; action_in = 16'd5;
    cyc(); check("bad_pulse", 16'(bad_action), 16'd1);
    check("bad_own", 16'(own_out), 16'd1);
    action_valid = 1'b0;
    cyc(); check("bad_clear", 16'(bad_action), 16'd0);
    check("bad_own2", 16'(own_out), 16'd1);

    // Async reset mid-stream
    price_valid = 1'b1; price_in = 8'd4;
    cyc(); check("pre_rst_out", stock_out, 16'h8864);
    price_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 16'(stock_valid), 16'd0);
    check("arst_out", stock_out, 16'h0000);
    check("arst_own", 16'(own_out), 16'd0);
    @(negedge clk);
    rst = 1'b1; price_valid = 1'b1; price_in = 8'd7;
    cyc(); check("rr_a1", 16'(stock_valid), 16'd0);
    cyc(); check("rr_a2", 16'(stock_valid), 16'd0);
    cyc(); check("rr_a3_out", stock_out, 16'h1CE7);
    check("rr_a3_valid", 16'(stock_valid), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/price_window_packer.md
Name: price_window_packer

Overview:
- Upstream feeder for the day_trading decision stage.
- Accepts one daily closing price per handshake and keeps a sliding 3-day window.
- Tracks stock ownership from the decision stage's action feedback.
- Emits the packed 16-bit word {own, day1, day2, day3} through a one-entry valid/ready output register; day3 is the newest price.

Parameters:
- IN_W, 8, width of raw price input (must be >= 5).
- PRICE_W, 5, packed price field width (fixed by the 16-bit word format; not to be overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous window clear (new symbol).
- price_valid  in  1  price_in valid.
- price_in  in  IN_W  raw daily price, unsigned.
- price_ready  out  1  price accepted this cycle when price_valid && price_ready.
- action_valid  in  1  action_in valid.
- action_in  in  16  action code from the decision stage.
- stock_out  out  16  {own, day1[4:0], day2[4:0], day3[4:0]}.
- stock_valid  out  1  stock_out valid.
- stock_ready  in  1  consumer accepts stock_out.
- own_out  out  1  current ownership flag.
- bad_action  out  1  one-cycle pulse on an unrecognised action code.

Behaviour:
- Reset (rst=0, async): window d1/d2/d3=0, fill state EMPTY, own=0, stock_out=0, stock_valid=0, bad_action=0. price_ready=1 once rst releases and flush=0.
- price_ready = !flush && (!stock_valid || stock_ready), combinational.
- Price narrowing to 5 bits follows the optional feature below.
- On accept: d1<=d2, d2<=d3, d3<=narrowed price.
- Fill FSM: EMPTY -> FILL1 -> FILL2 -> STREAM, advancing on each accept. STREAM is absorbing until flush or reset.
- Emission:
  - An accept in FILL2 or STREAM loads stock_out = {own_next, d1, d2, d3} (post-shift) and sets stock_valid on the next edge. Latency is 1 cycle.
  - Accepts in EMPTY or FILL1 emit nothing.
- stock_valid clears on the edge where stock_ready=1 and no new emission occurs.
- Accept and drain in the same cycle: the new word replaces the old and stock_valid stays 1.
- While stock_valid && !stock_ready, stock_out is held bit-stable and price_ready=0.
- Ownership update on action_valid:
  - code 1 -> own=0.
  - codes 3, 4, 7 -> own=1.
  - codes 2, 8 -> own unchanged.
  - any other code -> own unchanged and bad_action=1 for one cycle.
- own_next is the value after any same-cycle action update, so an action and a price in the same cycle pack the updated own.
- flush=1:
  - Next edge: window zeroed, FSM to EMPTY, stock_valid=0 (a pending word is dropped).
  - own is preserved.
  - price_ready=0 during flush, so no price is accepted that cycle.
- Reset mid-stream: outputs clear immediately (async); the FSM restarts at EMPTY.

Optional Feature:
- Macro: PRICE_SAT_EN.
- Defined: price_in > 31 saturates to 31.
- Undefined: price narrowed by truncation to price_in[4:0].

Decomposition:
- Shared package day_trading_pkg holds:
  - action code localparams: ACT_SELL_ALL=1, ACT_STAY_OUT=2, ACT_BUY_MORE=3, ACT_BUY_LOT=4, ACT_BUY_LITTLE=7, ACT_HOLD=8;
  - PRICE_W=5;
  - fill-state enum {EMPTY, FILL1, FILL2, STREAM};
  - word-packing field offsets (OWN_BIT=15).
- One natural sub-module, own_tracker: action decode, own register and bad_action pulse.

Test Plan:
- Window fill: reset, own=0, accept prices 10, 10, 10 with stock_ready=1 -> stock_valid rises 1 cycle after the 3rd accept with stock_out=0x294A; no valid after the 1st or 2nd accept.
- Streaming: accept price 13 -> 0x294D. Then action_valid with code 7 and, in the same cycle, accept price 12 -> own_out=1 and stock_out=0xA9AC. Then code 1 -> own_out=0.
- Backpressure: stock_ready=0 after an emission -> price_ready=0 and stock_out stable for 5 cycles. Then stock_ready=1 with price 9 presented -> drain and new accept occur in the same cycle, and stock_valid stays 1.
- Overrange price: price_in=200 -> day3 field 31 with PRICE_SAT_EN, 8 without.
- Flush and reset: flush after 2 accepts -> no stock_valid until 3 further accepts, and own is preserved. rst asserted mid-STREAM -> stock_valid=0 without waiting for a clock edge.
- Unknown action: action_in=5 -> bad_action high for exactly 1 cycle, own unchanged.
